// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared image-pipeline phases, pixel values, threshold FSM states and compare helper
package img_pkg;

    localparam logic [2:0] GS_BOX_FILTER = 3'd1;
    localparam logic [2:0] GS_THRESHOLD  = 3'd2;

    localparam logic [7:0] PIX_FG = 8'hFF;
    localparam logic [7:0] PIX_BG = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } thr_state_t;

    // 9-bit sum so src + offset never wraps; equality is background
    function automatic logic [7:0] threshold_pixel(input logic [7:0] src,
                                                   input logic [7:0] mean,
                                                   input logic [7:0] offset);
        return (({1'b0, src} + {1'b0, offset}) > {1'b0, mean}) ? PIX_FG : PIX_BG;
    endfunction

endpackage

// File: rtl/threshold_read_pipe.sv
// rtl/threshold_read_pipe.sv - READ_LATENCY-deep delay line of {valid, pos, offset} with synchronous flush
module threshold_read_pipe #(
    parameter int READ_LATENCY = 1,
    parameter int POS_BITS     = 16
) (
    input  logic                clock,
    input  logic                not_reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [POS_BITS-1:0] in_pos,
    input  logic [7:0]          in_offset,
    output logic                tail_valid,
    output logic [POS_BITS-1:0] tail_pos,
    output logic [7:0]          tail_offset
);

    logic [READ_LATENCY-1:0] vld;
    logic [POS_BITS-1:0]     pos [READ_LATENCY];
    logic [7:0]              off [READ_LATENCY];

    // shift request tags in step with the RAM read latency; flush kills every in-flight read
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pos[i] <= '0;
                off[i] <= '0;
            end
        end else begin
            vld[0] <= flush ? 1'b0 : in_valid;
            pos[0] <= in_pos;
            off[0] <= in_offset;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld[i] <= flush ? 1'b0 : vld[i-1];
                pos[i] <= pos[i-1];
                off[i] <= off[i-1];
            end
        end
    end

    assign tail_valid  = vld[READ_LATENCY-1];
    assign tail_pos    = pos[READ_LATENCY-1];
    assign tail_offset = off[READ_LATENCY-1];

endmodule

// File: rtl/adaptive_threshold.sv
// rtl/adaptive_threshold.sv - streaming src-vs-mean binariser; optional ADAPTIVE_THRESHOLD_FG_COUNT_EN adds oFgCount
module adaptive_threshold
    import img_pkg::*;
#(
    parameter int WIDTH_BITS   = 8,
    parameter int HEIGHT_BITS  = 8,
    parameter int START_POS    = 0,
    parameter int END_POS      = (1 << (WIDTH_BITS + HEIGHT_BITS)) - 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   not_reset,
    output logic [WIDTH_BITS-1:0]  oReadCol,
    output logic [HEIGHT_BITS-1:0] oReadRow,
    input  logic [7:0]             iImageData,
    input  logic [7:0]             iMeanData,
    input  logic [7:0]             iOffset,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    output logic [7:0]             oResultData,
    output logic                   oResultWren,
    input  logic [2:0]             global_state,
    output logic                   finished
`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
    ,
    output logic [WIDTH_BITS+HEIGHT_BITS:0] oFgCount
`endif
);

    localparam int POS_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [POS_BITS-1:0] START_P = POS_BITS'(START_POS);
    localparam logic [POS_BITS-1:0] END_P   = POS_BITS'(END_POS);

    thr_state_t          state;
    logic [POS_BITS-1:0] rd_pos;
    logic [POS_BITS-1:0] wr_pos;   // oldest pixel whose write has not yet been seen outside
    logic [POS_BITS-1:0] res_pos;
    logic                wren_q;
    logic                gs_run;
    logic                commit;
    logic                tail_valid;
    logic [POS_BITS-1:0] tail_pos;
    logic [7:0]          tail_offset;

    assign gs_run = (global_state == GS_THRESHOLD);
    assign commit = wren_q && gs_run;

    threshold_read_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .POS_BITS     (POS_BITS)
    ) u_pipe (
        .clock       (clock),
        .not_reset   (not_reset),
        .flush       (!gs_run),
        .in_valid    ((state == ST_RUN) && gs_run),
        .in_pos      (rd_pos),
        .in_offset   (iOffset),
        .tail_valid  (tail_valid),
        .tail_pos    (tail_pos),
        .tail_offset (tail_offset)
    );

    // FSM, read/write position counters and the registered compare/write stage
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state       <= ST_IDLE;
            rd_pos      <= START_P;
            wr_pos      <= START_P;
            res_pos     <= START_P;
            wren_q      <= 1'b0;
            oResultData <= PIX_BG;
            finished    <= 1'b0;
        end else begin
            // a final write masked by a pause is held so it still appears once the phase returns
            if (!(state == ST_DONE && wren_q && !gs_run)) begin
                wren_q <= tail_valid && gs_run;
                if (tail_valid && gs_run) begin
                    oResultData <= threshold_pixel(iImageData, iMeanData, tail_offset);
                    res_pos     <= tail_pos;
                end
            end

            if (commit && wr_pos != END_P)
                wr_pos <= wr_pos + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (gs_run && !finished)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!gs_run) begin
                        state  <= ST_IDLE;
                        rd_pos <= wr_pos;
                    end else if (rd_pos == END_P) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_pos <= rd_pos + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!gs_run) begin
                        state  <= ST_IDLE;
                        rd_pos <= wr_pos;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase

            // last pixel being registered: done flag rises with its write strobe
            if (tail_valid && gs_run && tail_pos == END_P) begin
                state    <= ST_DONE;
                finished <= 1'b1;
            end
        end
    end

    assign oReadCol    = rd_pos[WIDTH_BITS-1:0];
    assign oReadRow    = rd_pos[POS_BITS-1:WIDTH_BITS];
    assign oResultCol  = res_pos[WIDTH_BITS-1:0];
    assign oResultRow  = res_pos[POS_BITS-1:WIDTH_BITS];
    assign oResultWren = wren_q && gs_run;

`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
    // count foreground pixels only when their write strobe is actually presented
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset)
            oFgCount <= '0;
        else if (commit && oResultData == PIX_FG)
            oFgCount <= oFgCount + 1'b1;
    end
`else
    // foreground counter not built
`endif

endmodule

// File: tb/tb_adaptive_threshold.sv
// tb/tb_adaptive_threshold.sv - directed bench for adaptive_threshold at read latencies 1, 2 and 3
module tb_adaptive_threshold;

    logic       clock = 1'b0;
    logic       not_reset;
    logic [2:0] global_state;
    logic [7:0] offset;
    logic       log_clr;

    logic [7:0] src_mem  [16];
    logic [7:0] mean_mem [16];
    logic [7:0] exp_mem  [16];
    int         exp_fg;

    logic [1:0] rd_col [3];
    logic [1:0] rd_row [3];
    logic [1:0] res_col [3];
    logic [1:0] res_row [3];
    logic [7:0] img [3];
    logic [7:0] mean [3];
    logic [7:0] res_data [3];
    logic       wren [3];
    logic       fin [3];
`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
    logic [4:0] fg_cnt [3];
`endif

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [3:0] a_pipe [3];

        always @(posedge clock) begin
            a_pipe[0] <= {rd_row[g], rd_col[g]};
            a_pipe[1] <= a_pipe[0];
            a_pipe[2] <= a_pipe[1];
        end

        assign img[g]  = src_mem[a_pipe[g]];
        assign mean[g] = mean_mem[a_pipe[g]];

        adaptive_threshold #(
            .WIDTH_BITS   (2),
            .HEIGHT_BITS  (2),
            .READ_LATENCY (g + 1)
        ) u_dut (
            .clock        (clock),
            .not_reset    (not_reset),
            .oReadCol     (rd_col[g]),
            .oReadRow     (rd_row[g]),
            .iImageData   (img[g]),
            .iMeanData    (mean[g]),
            .iOffset      (offset),
            .oResultCol   (res_col[g]),
            .oResultRow   (res_row[g]),
            .oResultData  (res_data[g]),
            .oResultWren  (wren[g]),
            .global_state (global_state),
            .finished     (fin[g])
`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
            ,
            .oFgCount     (fg_cnt[g])
`endif
        );
    end

    int         wr_cnt [3][16];
    logic [7:0] wr_dat [3][16];
    int         n_wr [3];
    int         order_err [3];
    int         fin_err [3];
    int         pause_err [3];
    int         first_cyc [3];
    int         last_cyc [3];
    int         last_addr [3];
    int         next_addr [3];

    always @(negedge clock) begin : mon
        int a;
        for (int k = 0; k < 3; k++) begin
            if (log_clr) begin
                for (int p = 0; p < 16; p++) begin
                    wr_cnt[k][p] = 0;
                    wr_dat[k][p] = 8'h5A;
                end
                n_wr[k] = 0; order_err[k] = 0; fin_err[k] = 0; pause_err[k] = 0;
                first_cyc[k] = -1; last_cyc[k] = -1; last_addr[k] = -1; next_addr[k] = 0;
            end else if (wren[k]) begin
                a = int'({res_row[k], res_col[k]});
                wr_cnt[k][a] = wr_cnt[k][a] + 1;
                wr_dat[k][a] = res_data[k];
                if (a != next_addr[k]) order_err[k] = order_err[k] + 1;
                next_addr[k] = a + 1;
                if ((a == 15) != (fin[k] === 1'b1)) fin_err[k] = fin_err[k] + 1;
                if (global_state != 3'd2) pause_err[k] = pause_err[k] + 1;
                if (first_cyc[k] < 0) first_cyc[k] = cyc;
                last_cyc[k] = cyc;
                last_addr[k] = a;
                n_wr[k] = n_wr[k] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge clock);
        #1;
        log_clr = 1'b0;
    endtask

    // hand-picked per-pixel vectors; even pixels foreground, odd background except kind 0
    task automatic load_frame(input int kind);
        exp_fg = 0;
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0: begin src_mem[i] = 8'd100; mean_mem[i] = 8'd100; exp_mem[i] = 8'h00; end
                1: begin
                    src_mem[i]  = (i % 2 == 0) ? 8'd91 : 8'd90;
                    mean_mem[i] = 8'd100;
                    exp_mem[i]  = (i % 2 == 0) ? 8'hFF : 8'h00;
                end
                2: begin
                    src_mem[i]  = (i % 2 == 0) ? 8'd120 : 8'd0;
                    mean_mem[i] = (i % 2 == 0) ? 8'd100 : 8'd0;
                    exp_mem[i]  = (i % 2 == 0) ? 8'hFF : 8'h00;
                end
                default: begin
                    src_mem[i]  = (i % 2 == 0) ? 8'd255 : 8'd0;
                    mean_mem[i] = 8'd255;
                    exp_mem[i]  = (i % 2 == 0) ? 8'hFF : 8'h00;
                end
            endcase
            if (exp_mem[i] == 8'hFF) exp_fg++;
        end
    endtask

    task automatic restart();
        not_reset = 1'b0;
        global_state = 3'd0;
        tick();
        clear_log();
        not_reset = 1'b1;
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (fin[0] && fin[1] && fin[2]) break;
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag);
        int bad_cnt;
        int bad_dat;
        for (int k = 0; k < 3; k++) begin
            bad_cnt = 0;
            bad_dat = 0;
            for (int p = 0; p < 16; p++) begin
                if (wr_cnt[k][p] != 1) bad_cnt++;
                if (wr_dat[k][p] !== exp_mem[p]) bad_dat++;
            end
            check($sformatf("%s_rl%0d_writes", tag, k + 1), n_wr[k], 16);
            check($sformatf("%s_rl%0d_not_once", tag, k + 1), bad_cnt, 0);
            check($sformatf("%s_rl%0d_data_bad", tag, k + 1), bad_dat, 0);
            check($sformatf("%s_rl%0d_order_err", tag, k + 1), order_err[k], 0);
            check($sformatf("%s_rl%0d_finished", tag, k + 1), 32'(fin[k]), 1);
            check($sformatf("%s_rl%0d_fin_align", tag, k + 1), fin_err[k], 0);
            check($sformatf("%s_rl%0d_paused_wren", tag, k + 1), pause_err[k], 0);
`ifdef ADAPTIVE_THRESHOLD_FG_COUNT_EN
            check($sformatf("%s_rl%0d_fg_count", tag, k + 1), 32'(fg_cnt[k]), exp_fg);
`endif
        end
    endtask

    initial begin
        int c0;
        not_reset = 1'b0;
        global_state = 3'd0;
        offset = 8'd0;
        log_clr = 1'b0;
        load_frame(0);
        repeat (3) tick();

        // reset state
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_wren_rl%0d", k + 1), 32'(wren[k]), 0);
            check($sformatf("rst_data_rl%0d", k + 1), 32'(res_data[k]), 0);
            check($sformatf("rst_fin_rl%0d", k + 1), 32'(fin[k]), 0);
            check($sformatf("rst_rdaddr_rl%0d", k + 1), 32'({rd_row[k], rd_col[k]}), 0);
        end
        clear_log();
        not_reset = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("idle_gs0_writes_rl%0d", k + 1), n_wr[k], 0);

        // T1 / T5: all-equal frame, latency of first and last write
        c0 = cyc;
        global_state = 3'd2;
        wait_done();
        check_frame("t1");
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t5_first_lat_rl%0d", k + 1), first_cyc[k] - c0, k + 3);
            check($sformatf("t5_last_lat_rl%0d", k + 1), last_cyc[k] - c0, k + 3 + 15);
            check($sformatf("t5_last_addr_rl%0d", k + 1), last_addr[k], 15);
        end

        // T2 / T4: offset 10 equality edge, paused for 3 cycles mid-frame
        load_frame(1);
        offset = 8'd10;
        restart();
        global_state = 3'd2;
        repeat (6) tick();
        global_state = 3'd0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("t4_fin_paused_rl%0d", k + 1), 32'(fin[k]), 0);
        global_state = 3'd2;
        wait_done();
        check_frame("t4");

        // T2 / T3: plain src > mean with C=0, including 0 vs 0
        load_frame(2);
        offset = 8'd0;
        restart();
        global_state = 3'd2;
        wait_done();
        check_frame("t2");

        // T3: 9-bit overflow edge with C=255
        load_frame(3);
        offset = 8'd255;
        restart();
        global_state = 3'd2;
        wait_done();
        check_frame("t3");

        // T6: reset mid-run, then a full rerun
        load_frame(2);
        offset = 8'd0;
        restart();
        global_state = 3'd2;
        repeat (8) tick();
        #3;
        not_reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6_rst_wren_rl%0d", k + 1), 32'(wren[k]), 0);
            check($sformatf("t6_rst_data_rl%0d", k + 1), 32'(res_data[k]), 0);
            check($sformatf("t6_rst_addr_rl%0d", k + 1), 32'({res_row[k], res_col[k]}), 0);
        end
        tick();
        clear_log();
        not_reset = 1'b1;
        wait_done();
        check_frame("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
